// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the dmem arbiter, its two requesters (CPU, VGA) and dmem.
// slave = arbiter view, master = requesters plus memory view.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_valid;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  vga_req, vga_addr,
    output vga_rdata, vga_valid,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output vga_req, vga_addr,
    input  vga_rdata, vga_valid,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between the CPU load/store port and the VGA pixel fetcher.
// One access in flight; CPU preferred, VGA protected by a starvation counter.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned VGA_MAX_WAIT = 4
) (
  input  logic           sysclk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(VGA_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(VGA_MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RESP} state_t;
  typedef enum logic {OWN_CPU, OWN_VGA} owner_t;

  state_t            r_state;
  owner_t            r_owner;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_ready;
  logic              r_vga_valid;
  logic [CNT_W-1:0]  r_wait_cnt;

  logic w_cpu_elig;
  logic w_vga_elig;
  logic w_arb_ok;
  logic w_cpu_win;
  logic w_vga_win;

  // A requester completing this cycle still shows its stale req; mask it.
  assign w_cpu_elig = bus.cpu_req & ~r_cpu_ready;
  assign w_vga_elig = bus.vga_req & ~r_vga_valid;

  always_comb begin
    w_arb_ok  = (r_state == S_IDLE) || (r_state == S_RESP);
    w_cpu_win = 1'b0;
    w_vga_win = 1'b0;
    if (w_arb_ok) begin
      if (w_cpu_elig && w_vga_elig) begin
        if (r_wait_cnt >= CNT_MAX) w_vga_win = 1'b1;
        else                       w_cpu_win = 1'b1;
      end else if (w_cpu_elig) begin
        w_cpu_win = 1'b1;
      end else if (w_vga_elig) begin
        w_vga_win = 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_CPU;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_ready <= 1'b0;
      r_vga_valid <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      r_mem_we    <= 1'b0;
      r_cpu_ready <= 1'b0;
      r_vga_valid <= 1'b0;

      if (!bus.vga_req || w_vga_win)
        r_wait_cnt <= '0;
      else if (r_wait_cnt < CNT_MAX)
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);

      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_cpu_win) begin
            r_state     <= S_GRANT;
            r_owner     <= OWN_CPU;
            r_mem_we    <= bus.cpu_we;
            r_mem_addr  <= bus.cpu_addr;
            r_mem_wdata <= bus.cpu_wdata;
          end else if (w_vga_win) begin
            r_state    <= S_GRANT;
            r_owner    <= OWN_VGA;
            r_mem_addr <= bus.vga_addr;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GRANT: begin
          r_state <= S_RESP;
          if (r_owner == OWN_CPU) r_cpu_ready <= 1'b1;
          else                    r_vga_valid <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.cpu_ready = r_cpu_ready;
  assign bus.vga_valid = r_vga_valid;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.vga_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus random checks of dmem_arbiter against hand-computed timelines and a memory model.
// u_dut1 (VGA_MAX_WAIT=2) mirrors u_dut0's inputs and exercises the forced VGA win.
module tb_dmem_arbiter;

  logic sysclk;
  logic reset;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .VGA_MAX_WAIT(4)) u_dut0 (
    .sysclk(sysclk), .reset(reset), .bus(bus0));
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .VGA_MAX_WAIT(2)) u_dut1 (
    .sysclk(sysclk), .reset(reset), .bus(bus1));

  assign bus1.cpu_req   = bus0.cpu_req;
  assign bus1.cpu_we    = bus0.cpu_we;
  assign bus1.cpu_addr  = bus0.cpu_addr;
  assign bus1.cpu_wdata = bus0.cpu_wdata;
  assign bus1.vga_req   = bus0.vga_req;
  assign bus1.vga_addr  = bus0.vga_addr;

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Synchronous-read data memories, preloaded with 0x1000_0000 + word index on reset.
  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];

  always @(posedge sysclk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= 32'h1000_0000 + 32'(i);
        mem1[i] <= 32'h1000_0000 + 32'(i);
      end
      bus0.mem_rdata <= '0;
      bus1.mem_rdata <= '0;
    end else begin
      if (bus0.mem_we) mem0[bus0.mem_addr[9:2]] <= bus0.mem_wdata;
      if (bus1.mem_we) mem1[bus1.mem_addr[9:2]] <= bus1.mem_wdata;
      bus0.mem_rdata <= mem0[bus0.mem_addr[9:2]];
      bus1.mem_rdata <= mem1[bus1.mem_addr[9:2]];
    end
  end

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  logic [31:0] ref_mem [256];
  int          c_idx, v_idx, cwait, vwait, max_cw, max_vw, nwe, nwr, dual;
  logic        c_we;
  logic [31:0] c_wd;

  initial begin
    reset          = 1'b1;
    bus0.cpu_req   = 1'b0;
    bus0.cpu_we    = 1'b0;
    bus0.cpu_addr  = '0;
    bus0.cpu_wdata = '0;
    bus0.vga_req   = 1'b0;
    bus0.vga_addr  = '0;
    repeat (3) step();

    chk("rst_mem_we",    32'(bus0.mem_we),    0);
    chk("rst_mem_addr",  bus0.mem_addr,       0);
    chk("rst_mem_wdata", bus0.mem_wdata,      0);
    chk("rst_cpu_ready", 32'(bus0.cpu_ready), 0);
    chk("rst_vga_valid", 32'(bus0.vga_valid), 0);
    reset = 1'b0;
    step();

    // CPU write then read-back, VGA idle
    bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b1;
    bus0.cpu_addr = 32'h40; bus0.cpu_wdata = 32'hDEAD_BEEF;
    step();
    chk("t1_we_grant",  32'(bus0.mem_we),    1);
    chk("t1_addr",      bus0.mem_addr,       32'h40);
    chk("t1_wdata",     bus0.mem_wdata,      32'hDEAD_BEEF);
    chk("t1_rdy_early", 32'(bus0.cpu_ready), 0);
    step();
    chk("t1_we_resp",   32'(bus0.mem_we),    0);
    chk("t1_rdy",       32'(bus0.cpu_ready), 1);
    chk("t1_addr_hold", bus0.mem_addr,       32'h40);
    bus0.cpu_req = 1'b0; bus0.cpu_we = 1'b0;
    step();
    chk("t1_rdy_pulse", 32'(bus0.cpu_ready), 0);
    bus0.cpu_req = 1'b1;
    step();
    chk("t1_rd_we",     32'(bus0.mem_we),    0);
    step();
    chk("t1_rd_rdy",    32'(bus0.cpu_ready), 1);
    chk("t1_rd_data",   bus0.cpu_rdata,      32'hDEAD_BEEF);
    bus0.cpu_req = 1'b0;
    repeat (2) step();

    // VGA-only reads: one completion every 3 cycles
    bus0.vga_req = 1'b1; bus0.vga_addr = 32'h0;
    for (int i = 1; i <= 9; i++) begin
      step();
      chk("t4_valid", 32'(bus0.vga_valid), 32'(i % 3 == 2));
      chk("t4_cpu_rdy", 32'(bus0.cpu_ready), 0);
      if (i % 3 == 2) begin
        chk("t4_rdata", bus0.vga_rdata, 32'h1000_0000 + 32'(i / 3));
        bus0.vga_addr = bus0.vga_addr + 32'h4;
      end
    end
    bus0.vga_req = 1'b0;
    repeat (2) step();

    // Both held continuously: CPU first, then strict alternation
    bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 32'h40;
    bus0.vga_req = 1'b1; bus0.vga_addr = 32'h8;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("t2_cpu_rdy", 32'(bus0.cpu_ready), 32'(i % 4 == 2));
      chk("t2_vga_vld", 32'(bus0.vga_valid), 32'(i % 4 == 0));
      if (i % 4 == 2) chk("t2_cpu_data", bus0.cpu_rdata, 32'hDEAD_BEEF);
      if (i % 4 == 0) chk("t2_vga_data", bus0.vga_rdata, 32'h1000_0002);
    end
    bus0.cpu_req = 1'b0; bus0.vga_req = 1'b0;
    repeat (2) step();

    // Tie in IDLE after VGA's own access: wait_cnt=2, so VGA wins only when VGA_MAX_WAIT=2
    bus0.vga_req = 1'b1; bus0.vga_addr = 32'h10;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("t3_d0_vld", 32'(bus0.vga_valid), 32'(i == 2 || i == 7));
      chk("t3_d0_rdy", 32'(bus0.cpu_ready), 32'(i == 5));
      chk("t3_d1_vld", 32'(bus1.vga_valid), 32'(i == 2 || i == 5));
      chk("t3_d1_rdy", 32'(bus1.cpu_ready), 32'(i == 7));
      if (i == 5) chk("t3_d1_data", bus1.vga_rdata, 32'h1000_0004);
      if (i == 3) begin
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 32'h40;
      end
    end
    bus0.cpu_req = 1'b0; bus0.vga_req = 1'b0;
    repeat (2) step();

    // Reset during GRANT of a CPU write abandons it
    bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b1;
    bus0.cpu_addr = 32'h80; bus0.cpu_wdata = 32'h1234_5678;
    step();
    chk("t5_we_grant", 32'(bus0.mem_we), 1);
    reset = 1'b1;
    step();
    chk("t5_we",    32'(bus0.mem_we),    0);
    chk("t5_rdy",   32'(bus0.cpu_ready), 0);
    chk("t5_vld",   32'(bus0.vga_valid), 0);
    chk("t5_addr",  bus0.mem_addr,       0);
    chk("t5_wdata", bus0.mem_wdata,      0);
    bus0.cpu_req = 1'b0; bus0.cpu_we = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_rdy", 32'(bus0.cpu_ready), 0);
      chk("t5_no_we",  32'(bus0.mem_we),    0);
    end

    // Random traffic against a reference memory
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
    cwait = 0; vwait = 0; max_cw = 0; max_vw = 0; nwe = 0; nwr = 0; dual = 0;
    c_idx = 0; v_idx = 0; c_we = 1'b0; c_wd = '0;
    for (int cyc = 0; cyc < 10010; cyc++) begin
      step();
      if (bus0.cpu_ready && bus0.vga_valid) dual++;
      if (bus0.mem_we) nwe++;

      if (bus0.cpu_ready) begin
        if (c_we) begin
          ref_mem[c_idx] = c_wd;
          nwr++;
        end else begin
          chk("rnd_cpu_data", bus0.cpu_rdata, ref_mem[c_idx]);
        end
        bus0.cpu_req = 1'b0;
        cwait = 0;
      end else if (bus0.cpu_req) begin
        cwait++;
        if (cwait > max_cw) max_cw = cwait;
      end else if (cyc < 10000 && $urandom_range(2) == 0) begin
        c_idx = int'($urandom_range(255));
        c_we  = 1'($urandom_range(1));
        c_wd  = $urandom;
        bus0.cpu_req   = 1'b1;
        bus0.cpu_we    = c_we;
        bus0.cpu_addr  = {22'b0, c_idx[7:0], 2'b00};
        bus0.cpu_wdata = c_wd;
      end

      if (bus0.vga_valid) begin
        chk("rnd_vga_data", bus0.vga_rdata, ref_mem[v_idx]);
        bus0.vga_req = 1'b0;
        vwait = 0;
      end else if (bus0.vga_req) begin
        vwait++;
        if (vwait > max_vw) max_vw = vwait;
      end else if (cyc < 10000 && $urandom_range(3) == 0) begin
        v_idx = int'($urandom_range(255));
        bus0.vga_req  = 1'b1;
        bus0.vga_addr = {22'b0, v_idx[7:0], 2'b00};
      end
    end
    chk("rnd_we_pulses", 32'(nwe), 32'(nwr));
    chk("rnd_dual",      32'(dual), 0);
    chk("rnd_vga_wait",  32'(max_vw <= 6), 1);
    chk("rnd_cpu_wait",  32'(max_cw <= 6), 1);
    chk("rnd_drained",   {30'b0, bus0.cpu_req, bus0.vga_req}, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
